sram_mem_controller: RTL and testbench
======================================

Name: sram_mem_controller

Overview:
- MEM-stage data-memory controller that replaces the single-cycle data memory with an external 16-bit asynchronous SRAM.
- Accepts a 32-bit load/store from the EXE/MEM register: address = ALU result, write data = Rm value.
- Performs two 16-bit SRAM accesses plus programmable wait cycles.
- Deasserts ready while busy. The top level ties pipeline freeze to ~ready for IF/ID/EXE/MEM registers.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 2: extra wait cycles after the two halfword phases (legal range 1..15).
- SRAM_AW, 18: SRAM halfword address width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- wr_en  in  1  store request, from EXE/MEM register.
- rd_en  in  1  load request, from EXE/MEM register.
- address  in  32  byte address (ALU result).
- write_data  in  32  store data (Rm value).
- read_data  out  32  load result, registered.
- ready  out  1  1 = no access in progress or access completing this cycle.
- sram_addr  out  SRAM_AW  halfword address.
- sram_dq_o  out  16  write data to SRAM.
- sram_dq_i  in  16  read data from SRAM (combinational SRAM model).
- sram_dq_oe  out  1  drive enable for the DQ bus.
- sram_we_n  out  1  active-low SRAM write strobe.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, counter=0, latched address/data=0.
  - read_data=0, sram_addr=0, sram_dq_o=0, sram_dq_oe=0, sram_we_n=1.
  - ready=1 while rst is high.
  - An access interrupted by reset is abandoned; no completion is signalled.
- Address map: word_idx = (address - BASE_ADDR) >> 2, 32-bit subtraction truncated to SRAM_AW-1 bits.
  - Low phase: sram_addr = {word_idx, 1'b0}. High phase: sram_addr = {word_idx, 1'b1}.
  - Out-of-range and below-base addresses wrap modulo the SRAM size. address[1:0] is ignored.
- Request = wr_en | rd_en. If both are high, the access is a write and read_data is unchanged.
- States:
  - IDLE: ready = ~request. On request, latch address, write_data and op, then go to LOW.
  - LOW: drive low halfword address.
    - Write: sram_dq_o = wdata[15:0], sram_dq_oe=1, sram_we_n=0.
    - Read: sram_dq_i is captured into read_data[15:0] at the clock edge ending this cycle.
    - Next state HIGH.
  - HIGH: same as LOW for the upper halfword (wdata[31:16] / read_data[31:16]). Load counter=WAIT_CYCLES-1, go to WAIT.
  - WAIT: SRAM idle (we_n=1, oe=0). Decrement counter; at 0 go to DONE.
  - DONE: ready=1 for exactly one cycle, read_data valid. Always go to IDLE.
- ready is combinational from state/request and is 0 in LOW, HIGH and WAIT.
- Latency: request seen in cycle 0; ready=0 for cycles 0..2+WAIT_CYCLES; ready=1 in cycle 3+WAIT_CYCLES. Default WAIT_CYCLES=2 gives 5 stall cycles, with DONE in cycle 5.
- Inputs are ignored outside IDLE, since the latched copy is used. The pipeline unfreezes in DONE, so the next instruction's request is evaluated in IDLE the following cycle.
- read_data holds its value until the next read's LOW/HIGH phase overwrites it. Writes never modify it.
- sram_we_n is low only in LOW/HIGH of a write. sram_dq_oe equals ~sram_we_n.

Decomposition:
- Shared package holds:
  - state enum {IDLE, LOW, HIGH, WAIT, DONE}, 3 bits;
  - BASE_ADDR default constant;
  - SRAM data width constant (16).
- No RTL sub-module is needed; FSM, counter and datapath live in one module.
- Testbench uses a separate sram_model: 2^SRAM_AW x 16 array, combinational read, write on we_n low at clock edge.

Test Plan:
- Write: wr_en=1, address=1032, write_data=0xDEADBEEF.
  - Cycle1: sram_addr=4, dq_o=0xBEEF, we_n=0.
  - Cycle2: sram_addr=5, dq_o=0xDEAD.
  - ready=0 in cycles 0-4 and 1 in cycle 5; model words 4/5 = 0xBEEF/0xDEAD.
- Read-back: rd_en=1, address=1032 → we_n stays 1; read_data=0xDEADBEEF in cycle 5 with ready=1.
- Back-to-back: store 0x12345678 @1040, then load @1040 presented the cycle after DONE → each access takes 6 cycles (12 total), load returns 0x12345678, no extra bubbles.
- Both enables: wr_en=rd_en=1, address=1024, data=0xA5A5_5A5A → SRAM words 0/1 written; read_data keeps its prior value.
- Wrap: store @1024+0x80000 → sram_addr 0 then 1. Store @1020 → sram_addr 0x3FFFE then 0x3FFFF.
- Reset mid-access: assert rst during HIGH of a write → immediately we_n=1, dq_oe=0, ready=1, read_data=0. After release, state=IDLE and a fresh read completes in 6 cycles.

Source files
------------

// File: rtl/sram_mem_controller_pkg.sv
// Shared types and constants for the MEM-stage SRAM data-memory controller.
package sram_mem_controller_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOW  = 3'd1,
      HIGH = 3'd2,
      WAIT = 3'd3,
      DONE = 3'd4
   } state_t;

   localparam int unsigned BASE_ADDR_DEFAULT = 1024;
   localparam int unsigned SRAM_DW           = 16;
   localparam int unsigned CNT_W             = 4;

endpackage

// File: rtl/sram_mem_controller_if.sv
// Pipeline-side load/store bus plus the external 16-bit asynchronous SRAM pins.
interface sram_mem_controller_if
   import sram_mem_controller_pkg::*;
#(
   parameter int unsigned SRAM_AW = 18
);

   logic                 wr_en;
   logic                 rd_en;
   logic [31:0]          address;
   logic [31:0]          write_data;
   logic [31:0]          read_data;
   logic                 ready;
   logic [SRAM_AW-1:0]   sram_addr;
   logic [SRAM_DW-1:0]   sram_dq_o;
   logic [SRAM_DW-1:0]   sram_dq_i;
   logic                 sram_dq_oe;
   logic                 sram_we_n;

   // master: pipeline + SRAM device side; slave: the controller itself
   modport master (
      output wr_en, rd_en, address, write_data, sram_dq_i,
      input  read_data, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
   );

   modport slave (
      input  wr_en, rd_en, address, write_data, sram_dq_i,
      output read_data, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
   );

endinterface

// File: rtl/sram_mem_controller.sv
// Splits a 32-bit load/store into two 16-bit SRAM accesses followed by a
// programmable number of wait cycles; ready low freezes the pipeline meanwhile.
module sram_mem_controller
   import sram_mem_controller_pkg::*;
#(
   parameter int unsigned BASE_ADDR   = BASE_ADDR_DEFAULT,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned SRAM_AW     = 18
) (
   input  logic                  clk,
   input  logic                  rst,
   sram_mem_controller_if.slave  bus
);

   state_t               state_q,  state_d;
   logic [CNT_W-1:0]     cnt_q,    cnt_d;
   logic [SRAM_AW-2:0]   widx_q,   widx_d;
   logic [31:0]          wdata_q,  wdata_d;
   logic                 is_wr_q,  is_wr_d;
   logic [31:0]          rdata_q,  rdata_d;
   logic [SRAM_AW-1:0]   addr_q,   addr_d;
   logic [SRAM_DW-1:0]   dqo_q,    dqo_d;
   logic                 we_n_q,   we_n_d;

   logic                 req;
   logic [SRAM_AW-2:0]   widx_in;

   assign req     = bus.wr_en | bus.rd_en;
   // Truncation makes out-of-range and below-base addresses wrap around the SRAM.
   assign widx_in = (SRAM_AW-1)'((bus.address - 32'(BASE_ADDR)) >> 2);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      widx_d  = widx_q;
      wdata_d = wdata_q;
      is_wr_d = is_wr_q;
      rdata_d = rdata_q;
      addr_d  = addr_q;
      dqo_d   = dqo_q;
      we_n_d  = we_n_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               widx_d  = widx_in;
               wdata_d = bus.write_data;
               is_wr_d = bus.wr_en;
               addr_d  = {widx_in, 1'b0};
               dqo_d   = bus.write_data[15:0];
               we_n_d  = ~bus.wr_en;
               state_d = LOW;
            end
         end
         LOW: begin
            if (!is_wr_q) rdata_d[15:0] = bus.sram_dq_i;
            addr_d  = {widx_q, 1'b1};
            dqo_d   = wdata_q[31:16];
            we_n_d  = ~is_wr_q;
            state_d = HIGH;
         end
         HIGH: begin
            if (!is_wr_q) rdata_d[31:16] = bus.sram_dq_i;
            we_n_d  = 1'b1;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == '0) state_d = DONE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         widx_q  <= '0;
         wdata_q <= '0;
         is_wr_q <= 1'b0;
         rdata_q <= '0;
         addr_q  <= '0;
         dqo_q   <= '0;
         we_n_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         widx_q  <= widx_d;
         wdata_q <= wdata_d;
         is_wr_q <= is_wr_d;
         rdata_q <= rdata_d;
         addr_q  <= addr_d;
         dqo_q   <= dqo_d;
         we_n_q  <= we_n_d;
      end
   end

   // rst term keeps the pipeline unfrozen while reset is held, even with a request pending.
   assign bus.ready      = rst | ((state_q == IDLE) & ~req) | (state_q == DONE);
   assign bus.read_data  = rdata_q;
   assign bus.sram_addr  = addr_q;
   assign bus.sram_dq_o  = dqo_q;
   assign bus.sram_we_n  = we_n_q;
   assign bus.sram_dq_oe = ~we_n_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: table of load/store vectors with a read-data
// scoreboard, plus hand-written reset and back-to-back sequences.
module tb_sram_mem_controller;

   localparam int unsigned AW    = 18;
   localparam int unsigned WAITC = 2;
   localparam int          NVEC  = 10;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   int   cyc;

   sram_mem_controller_if #(.SRAM_AW(AW)) bus ();

   sram_mem_controller #(
      .BASE_ADDR   (1024),
      .WAIT_CYCLES (WAITC),
      .SRAM_AW     (AW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Behavioural async SRAM: combinational read, write on we_n low at the edge.
   logic [15:0] mem [0:(1<<AW)-1];
   assign bus.sram_dq_i = mem[bus.sram_addr];
   always @(posedge clk) begin
      if (!bus.sram_we_n) mem[bus.sram_addr] <= bus.sram_dq_o;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic [17:0] exp_lo;
   } vec_t;

   vec_t        vecs [NVEC];
   logic [31:0] exp_q [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run_access(input int id, input logic wr, input logic rd,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] exp_rd, input logic [17:0] exp_lo);
      int          lat;
      bit          done;
      logic [31:0] e;
      bus.wr_en      = wr;
      bus.rd_en      = rd;
      bus.address    = addr;
      bus.write_data = wd;
      exp_q.push_back(exp_rd);
      #1;
      chk($sformatf("a%0d_ready_c0", id), 32'(bus.ready), 32'd0);
      lat  = 0;
      done = 0;
      while (!done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1 || lat == 2) begin
            chk($sformatf("a%0d_addr_c%0d", id, lat), 32'(bus.sram_addr),
                32'(exp_lo) + 32'(lat - 1));
            chk($sformatf("a%0d_we_n_c%0d", id, lat), 32'(bus.sram_we_n), 32'(!wr));
            chk($sformatf("a%0d_oe_c%0d", id, lat), 32'(bus.sram_dq_oe), 32'(wr));
            if (wr)
               chk($sformatf("a%0d_dq_c%0d", id, lat), 32'(bus.sram_dq_o),
                   (lat == 1) ? 32'(wd[15:0]) : 32'(wd[31:16]));
         end
         if (lat == 3)
            chk($sformatf("a%0d_we_n_wait", id), 32'(bus.sram_we_n), 32'd1);
         if (bus.ready) done = 1;
      end
      chk($sformatf("a%0d_latency", id), 32'(lat), 32'(3 + WAITC));
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL a%0d_scoreboard: got empty queue expected one entry", id);
      end else begin
         e = exp_q.pop_front();
         chk($sformatf("a%0d_read_data", id), bus.read_data, e);
      end
      if (wr) begin
         chk($sformatf("a%0d_mem_lo", id), 32'(mem[exp_lo]), 32'(wd[15:0]));
         chk($sformatf("a%0d_mem_hi", id), 32'(mem[exp_lo | 18'd1]), 32'(wd[31:16]));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int t0;
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      vecs[0] = '{1'b1, 1'b0, 32'd1032,       32'hDEADBEEF, 32'h00000000, 18'd4};
      vecs[1] = '{1'b0, 1'b1, 32'd1032,       32'h00000000, 32'hDEADBEEF, 18'd4};
      vecs[2] = '{1'b1, 1'b0, 32'd1040,       32'h12345678, 32'hDEADBEEF, 18'd8};
      vecs[3] = '{1'b0, 1'b1, 32'd1040,       32'h00000000, 32'h12345678, 18'd8};
      vecs[4] = '{1'b1, 1'b1, 32'd1024,       32'hA5A55A5A, 32'h12345678, 18'd0};
      vecs[5] = '{1'b0, 1'b1, 32'd1024,       32'h00000000, 32'hA5A55A5A, 18'd0};
      vecs[6] = '{1'b1, 1'b0, 32'h00080400,   32'h0BADF00D, 32'hA5A55A5A, 18'd0};
      vecs[7] = '{1'b1, 1'b0, 32'd1020,       32'hCAFEF00D, 32'hA5A55A5A, 18'h3FFFE};
      vecs[8] = '{1'b0, 1'b1, 32'd1027,       32'h00000000, 32'h0BADF00D, 18'd0};
      vecs[9] = '{1'b0, 1'b1, 32'd1020,       32'h00000000, 32'hCAFEF00D, 18'h3FFFE};

      rst            = 1'b1;
      bus.wr_en      = 1'b0;
      bus.rd_en      = 1'b0;
      bus.address    = '0;
      bus.write_data = '0;
      #2;
      chk("rst_ready", 32'(bus.ready), 32'd1);
      chk("rst_we_n", 32'(bus.sram_we_n), 32'd1);
      chk("rst_oe", 32'(bus.sram_dq_oe), 32'd0);
      chk("rst_read_data", bus.read_data, 32'd0);
      chk("rst_addr", 32'(bus.sram_addr), 32'd0);
      chk("rst_dq_o", 32'(bus.sram_dq_o), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("idle_ready", 32'(bus.ready), 32'd1);
      @(posedge clk);
      #1;

      t0 = 0;
      for (int i = 0; i < NVEC; i++) begin
         if (i == 2) t0 = cyc;
         if (i == 4) chk("b2b_cycles", 32'(cyc - t0), 32'd12);
         run_access(i, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wd,
                    vecs[i].exp_rd, vecs[i].exp_lo);
      end
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      #1;
      chk("idle_after_table_ready", 32'(bus.ready), 32'd1);

      // Reset landing in the HIGH phase of a write.
      @(posedge clk);
      #1;
      bus.wr_en      = 1'b1;
      bus.address    = 32'd1032;
      bus.write_data = 32'h11112222;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("rma_high_addr", 32'(bus.sram_addr), 32'd5);
      chk("rma_high_we_n", 32'(bus.sram_we_n), 32'd0);
      rst = 1'b1;
      #1;
      chk("rma_we_n", 32'(bus.sram_we_n), 32'd1);
      chk("rma_oe", 32'(bus.sram_dq_oe), 32'd0);
      chk("rma_ready", 32'(bus.ready), 32'd1);
      chk("rma_read_data", bus.read_data, 32'd0);
      bus.wr_en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rma_idle_ready", 32'(bus.ready), 32'd1);
      @(posedge clk);
      #1;
      // Low halfword was written before reset; the high write was abandoned.
      run_access(100, 1'b0, 1'b1, 32'd1032, 32'd0, 32'hDEAD2222, 18'd4);
      bus.rd_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
